// File: rtl/ex_mem_req_stage_pkg.sv
// Shared encodings for the EX->MEM request stage: access sizes, stage states,
// bypass bus width and the misalignment rule shared by the datapath and the FSM.
package ex_mem_req_stage_pkg;

  typedef enum logic [1:0] {
    MSZ_B = 2'd0,
    MSZ_H = 2'd1,
    MSZ_W = 2'd2,
    MSZ_D = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_REQ   = 2'd2
  } ex_state_e;

  function automatic int ex_mem_bus_w(input int xlen, input int rf_aw);
    return rf_aw + 2 + xlen;
  endfunction

  // A dword access on a 32-bit core has no legal alignment at all.
  function automatic logic ale_chk(input logic [1:0] size, input logic [2:0] lo,
                                   input int xlen);
    logic r;
    case (size)
      MSZ_H:   r = lo[0];
      MSZ_W:   r = |lo[1:0];
      MSZ_D:   r = (xlen != 64) || (|lo);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ex_mem_req_stage_st_align.sv
// Store alignment: byte strobes, lane-replicated write data and the
// misaligned-address flag for one access.
module ex_mem_req_stage_st_align
  import ex_mem_req_stage_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int WSTRB = XLEN / 8,
  localparam int OFFW  = $clog2(WSTRB)
) (
  input  logic [1:0]       i_size,
  input  logic [2:0]       i_lo,
  input  logic [XLEN-1:0]  i_data,
  output logic [WSTRB-1:0] o_wstrb,
  output logic [XLEN-1:0]  o_wdata,
  output logic             o_ale
);

  logic [WSTRB-1:0] w_mask;

  always_comb begin
    w_mask  = '1;
    o_wdata = i_data;
    case (i_size)
      MSZ_B: begin
        w_mask  = WSTRB'(1);
        o_wdata = {(XLEN/8){i_data[7:0]}};
      end
      MSZ_H: begin
        w_mask  = WSTRB'(3);
        o_wdata = {(XLEN/16){i_data[15:0]}};
      end
      MSZ_W: begin
        w_mask  = WSTRB'(15);
        o_wdata = {(XLEN/32){i_data[31:0]}};
      end
      default: begin
        w_mask  = '1;
        o_wdata = i_data;
      end
    endcase
  end

  assign o_wstrb = w_mask << i_lo[OFFW-1:0];
  assign o_ale   = ale_chk(i_size, i_lo, XLEN);

endmodule

// File: rtl/ex_mem_req_stage.sv
// EX stage in front of MEM: latches the ID bundle, forms the effective address
// and issues exactly one request/addr_ok transaction per memory instruction.
module ex_mem_req_stage
  import ex_mem_req_stage_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int WSTRB = XLEN / 8,
  parameter  int RF_AW = 5,
  localparam int BUS_W = ex_mem_bus_w(XLEN, RF_AW)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             id_valid,
  output logic             ex_allowin,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             in_rf_we,
  input  logic [RF_AW-1:0] in_rf_waddr,
  input  logic [XLEN-1:0]  in_result,
  input  logic             in_mem_rd,
  input  logic             in_mem_wr,
  input  logic [1:0]       in_mem_size,
  input  logic             in_ld_signed,
  input  logic [XLEN-1:0]  in_base,
  input  logic [XLEN-1:0]  in_offset,
  input  logic [XLEN-1:0]  in_st_data,
  input  logic             flush,
  input  logic             mem_allowin,
  output logic             ex_mem_valid,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_rf_we,
  output logic [RF_AW-1:0] out_rf_waddr,
  output logic [XLEN-1:0]  out_result,
  output logic             out_mem_rd,
  output logic [1:0]       out_mem_size,
  output logic             out_ld_signed,
  output logic             out_ale,
  output logic             out_cancel,
  output logic [BUS_W-1:0] fwd_bus,
  output logic             data_req,
  output logic             data_wr,
  output logic [1:0]       data_size,
  output logic [WSTRB-1:0] data_wstrb,
  output logic [XLEN-1:0]  data_addr,
  output logic [XLEN-1:0]  data_wdata,
  input  logic             data_addr_ok
);

  ex_state_e        r_state, w_nxt;
  logic [XLEN-1:0]  r_pc, r_result, r_base, r_offset, r_st_data;
  logic             r_rf_we, r_mem_rd, r_mem_wr, r_ld_signed;
  logic             r_issued, r_cancel;
  logic [RF_AW-1:0] r_waddr;
  logic [1:0]       r_size;

  logic [XLEN-1:0]  w_addr, w_wdata;
  logic [WSTRB-1:0] w_wstrb;
  logic             w_ale, w_mem_op, w_hold, w_busy, w_latch, w_in_ale, w_cancel;
  logic [2:0]       w_in_lo;

  assign w_addr   = r_base + r_offset;
  assign w_mem_op = r_mem_rd | r_mem_wr;
  assign w_hold   = (r_state == ST_HOLD);
  assign w_busy   = (r_state != ST_EMPTY);

  assign ex_allowin = (r_state == ST_EMPTY) | (w_hold & mem_allowin);
  assign w_latch    = id_valid & ex_allowin & ~flush;

  // Only the low address bits decide alignment, so the routing decision at
  // latch time needs just a 3-bit add on the incoming operands.
  assign w_in_lo  = in_base[2:0] + in_offset[2:0];
  assign w_in_ale = ale_chk(in_mem_size, w_in_lo, XLEN);

  ex_mem_req_stage_st_align #(.XLEN(XLEN)) u_st_align (
    .i_size  (r_size),
    .i_lo    (w_addr[2:0]),
    .i_data  (r_st_data),
    .o_wstrb (w_wstrb),
    .o_wdata (w_wdata),
    .o_ale   (w_ale)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_EMPTY;
    else         r_state <= w_nxt;
  end

  // An issued-but-flushed op stays until MEM takes it so the response drains.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_EMPTY, ST_HOLD: begin
        if (w_latch)
          w_nxt = ((in_mem_rd | in_mem_wr) & ~w_in_ale) ? ST_REQ : ST_HOLD;
        else if (ex_allowin)
          w_nxt = ST_EMPTY;
        else if (flush & ~r_issued)
          w_nxt = ST_EMPTY;
      end
      ST_REQ:  if (data_addr_ok) w_nxt = ST_HOLD;
      default: w_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc        <= '0;
      r_rf_we     <= 1'b0;
      r_waddr     <= '0;
      r_result    <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_size      <= '0;
      r_ld_signed <= 1'b0;
      r_base      <= '0;
      r_offset    <= '0;
      r_st_data   <= '0;
      r_issued    <= 1'b0;
      r_cancel    <= 1'b0;
    end else if (w_latch) begin
      r_pc        <= in_pc;
      r_rf_we     <= in_rf_we;
      r_waddr     <= in_rf_waddr;
      r_result    <= in_result;
      r_mem_rd    <= in_mem_rd;
      r_mem_wr    <= in_mem_wr;
      r_size      <= in_mem_size;
      r_ld_signed <= in_ld_signed;
      r_base      <= in_base;
      r_offset    <= in_offset;
      r_st_data   <= in_st_data;
      r_issued    <= 1'b0;
      r_cancel    <= 1'b0;
    end else begin
      if ((r_state == ST_REQ) && data_addr_ok) r_issued <= 1'b1;
      if (flush && ((r_state == ST_REQ) || (w_hold && r_issued))) r_cancel <= 1'b1;
    end
  end

  assign w_cancel = w_hold & (r_cancel | (flush & r_issued));

  assign ex_mem_valid  = w_hold;
  assign out_pc        = r_pc;
  assign out_rf_we     = r_rf_we & ~w_cancel;
  assign out_rf_waddr  = r_waddr;
  assign out_result    = w_mem_op ? w_addr : r_result;
  assign out_mem_rd    = r_mem_rd;
  assign out_mem_size  = r_size;
  assign out_ld_signed = r_ld_signed;
  assign out_ale       = w_hold & w_mem_op & w_ale;
  assign out_cancel    = w_cancel;

  // Occupancy (not just HOLD) so a load still waiting on addr_ok stalls ID.
  assign fwd_bus = {w_busy & r_mem_rd, w_busy & out_rf_we, r_waddr, out_result};

  assign data_req   = (r_state == ST_REQ);
  assign data_wr    = r_mem_wr;
  assign data_size  = r_size;
  assign data_addr  = w_addr;
  assign data_wstrb = r_mem_wr ? w_wstrb : '0;
  assign data_wdata = w_wdata;

endmodule

// File: doc/ex_mem_req_stage.md
Name: ex_mem_req_stage

Overview:
- Parametrised execute-stage successor for the 5-stage pipeline, between the ID stage and the MEM stage.
- Latches the ID bundle and computes the load/store effective address with an internal adder.
- Generates byte strobes and lane-replicated write data for 8/16/32-bit stores, plus 64-bit stores when XLEN=64.
- Drives a request/addr_ok data-memory handshake instead of single-cycle SRAM enables, and adds alignment-exception detection, pipeline flush and cancelled-request tracking.

Parameters:
- XLEN, 32, data and address width (32 or 64)
- WSTRB, XLEN/8, byte-strobe width (derived)
- RF_AW, 5, register-file address width

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- id_valid  in  1  ID bundle valid
- ex_allowin  out  1  stage can accept a new bundle
- in_pc  in  XLEN  instruction PC
- in_rf_we  in  1  writes register file
- in_rf_waddr  in  RF_AW  destination register
- in_result  in  XLEN  precomputed result for non-memory ops
- in_mem_rd  in  1  load
- in_mem_wr  in  1  store
- in_mem_size  in  2  0=byte 1=half 2=word 3=dword
- in_ld_signed  in  1  sign-extend load
- in_base  in  XLEN  address base operand
- in_offset  in  XLEN  address offset operand
- in_st_data  in  XLEN  store source register value
- flush  in  1  pipeline flush from WB
- mem_allowin  in  1  MEM stage accepts
- ex_mem_valid  out  1  bundle valid to MEM
- out_pc/out_rf_we/out_rf_waddr/out_mem_rd/out_mem_size/out_ld_signed  out  —  registered copies
- out_result  out  XLEN  effective address for memory ops, else in_result
- out_ale  out  1  misaligned-address exception
- out_cancel  out  1  request was issued but the instruction was flushed; MEM must drop its data_ok
- fwd_bus  out  RF_AW+2+XLEN  {is_load&valid, rf_we&valid, waddr, out_result} for bypass
- data_req  out  1  memory request
- data_wr  out  1  1=store
- data_size  out  2  access size
- data_wstrb  out  WSTRB  byte enables
- data_addr  out  XLEN  address
- data_wdata  out  XLEN  lane-replicated store data
- data_addr_ok  in  1  request accepted this cycle

Behaviour:
- Reset (asynchronous, resetn=0): state=EMPTY, all registered fields 0. ex_mem_valid, data_req, out_ale and out_cancel are 0.
- States:
  - EMPTY: no instruction held.
  - HOLD: holds a non-memory op, an ALE op, or a memory op whose request has already been accepted.
  - REQ: data_req=1, waiting for data_addr_ok.
- ex_allowin = EMPTY | (HOLD & mem_allowin). ex_allowin is 0 in REQ.
- Latch when id_valid & ex_allowin & ~flush.
  - Memory op without ALE goes to REQ the next cycle.
  - Any other op goes to HOLD.
  - If ex_allowin is high but nothing is latched, go to EMPTY.
- Address: addr = in_base + in_offset, computed combinationally on the latched operands, wrap modulo 2^XLEN.
- ALE = (size=1 & addr[0]) | (size=2 & |addr[1:0]) | (size=3 & |addr[2:0]). size=3 with XLEN=32 also raises ALE. An ALE op never raises data_req.
- REQ → HOLD on data_addr_ok. data_req drops the same cycle the handshake completes. Exactly one request per instruction, even if MEM stalls afterwards.
- data_addr, data_size, data_wstrb, data_wdata and data_wr are stable while data_req=1.
- wstrb lanes are selected by addr[log2(WSTRB)-1:0]:
  - byte: one lane
  - half: two lanes
  - word: four lanes
  - dword: all lanes
- wdata: byte replicated into every lane, half into every half, word into every word. Loads use wstrb=0.
- ex_mem_valid = HOLD (this includes cancelled instructions, so MEM can drain the response).
- Flush:
  - In EMPTY or HOLD: next state EMPTY.
  - In HOLD after a request was issued: the instruction is still passed once with out_cancel=1, rf_we forced to 0.
  - In REQ: data_req stays asserted until data_addr_ok (the protocol forbids withdrawal), then HOLD with out_cancel=1.
  - A flush in the same cycle as id_valid blocks the latch.
- Simultaneous HOLD→MEM handoff and new latch: back-to-back, with no bubble.

Decomposition:
- Shared package (mycpu.h extension): mem-size encodings, EX_MEM bus width macro, state encodings.
- One sub-module, st_align (combinational): size, addr low bits and data in; wstrb, wdata and ale out. Parametrised by XLEN.

Test Plan:
- XLEN=32, st.b, base=0x1000, offset=3, data=0x000000A5, addr_ok same cycle → data_req for 1 cycle, wstrb=4'b1000, wdata=0xA5A5A5A5, addr=0x1003.
- st.w to 0x1002 → no data_req, out_ale=1, ex_mem_valid the next cycle.
- ld.h at 0x2000, addr_ok held low for 3 cycles → data_req high 4 cycles with stable fields, ex_allowin=0 throughout, wstrb=0.
- Store accepted while mem_allowin=0 for 5 cycles → data_req deasserts after the handshake, no second request, ex_mem_valid held until mem_allowin.
- flush during REQ, addr_ok 2 cycles later → data_req stays until addr_ok, then ex_mem_valid=1 with out_cancel=1 and rf_we=0. The next id_valid is accepted afterwards.
- XLEN=64, sd at 0x...08, data 0x1122334455667788 → wstrb=8'hFF. sw at offset 4 → wstrb=8'hF0, wdata upper word=0x55667788. Assert resetn mid-REQ → data_req=0 immediately.
